// File: rtl/contador_n_modos.sv
// N-bit counter with up, down, down-by-STEP and parallel-load modes.
// Overflow and underflow can either wrap or clamp; RCO and ZERO are registered flags.
module contador_n_modos #(
  parameter int N        = 4,
  parameter int STEP     = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         iENB,
  input  logic [1:0]   iMODO,
  input  logic [N-1:0] iD,
  output logic [N-1:0] oQ,
  output logic         oRCO,
  output logic         oZERO
);

  localparam logic [N:0] STEP_EXT = (N+1)'(STEP);
  localparam logic [N:0] ONE_EXT  = (N+1)'(1);

  logic [N-1:0] q_reg, q_next;
  logic         rco_reg, rco_next;
  logic         zero_reg;
  logic [N:0]   q_ext;
  logic [N:0]   raw;

  assign q_ext = {1'b0, q_reg};

  // Bit N of the widened result is the carry (add) or borrow (subtract).
  always_comb begin
    raw      = q_ext;
    q_next   = q_reg;
    rco_next = 1'b0;
    if (iENB) begin
      case (iMODO)
        2'b00: begin
          raw      = q_ext + ONE_EXT;
          rco_next = raw[N];
          q_next   = (rco_next && SATURATE) ? {N{1'b1}} : raw[N-1:0];
        end
        2'b01: begin
          raw      = q_ext - ONE_EXT;
          rco_next = raw[N];
          q_next   = (rco_next && SATURATE) ? {N{1'b0}} : raw[N-1:0];
        end
        2'b10: begin
          raw      = q_ext - STEP_EXT;
          rco_next = raw[N];
          q_next   = (rco_next && SATURATE) ? {N{1'b0}} : raw[N-1:0];
        end
        default: begin
          q_next   = iD;
          rco_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_reg    <= '0;
      rco_reg  <= 1'b0;
      zero_reg <= 1'b1;
    end else begin
      q_reg    <= q_next;
      rco_reg  <= rco_next;
      zero_reg <= (q_next == '0);
    end
  end

  assign oQ    = q_reg;
  assign oRCO  = rco_reg;
  assign oZERO = zero_reg;

endmodule

// File: doc/contador_n_modos.md
# contador_n_modos

Parametrised N-bit synchronous counter with four operating modes: up by one, down by one, down by a configurable step, and parallel load. It succeeds the fixed 4-bit counter datapath and adds a selectable wrap/saturate policy, a registered zero flag and a single-cycle load path. It sits between the mode/control logic and any consumer that needs a registered count plus a ripple-carry-out (RCO) event.

## Interface
- N, default 4: counter width in bits; legal range N ≥ 2.
- STEP, default 3: decrement applied in mode 10; legal range 1 ≤ STEP ≤ 2^N−1.
- SATURATE, default 0: 0 = modular wrap; 1 = clamp at 0 and at 2^N−1.
- One clock; reset is asynchronous and active-high.
- CLK  input  1  system clock; all state updates on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- iENB  input  1  count enable; 0 freezes oQ.
- iMODO  input  2  operation select: 00 = +1, 01 = −1, 10 = −STEP, 11 = load.
- iD  input  N  load value, used only in mode 11.
- oQ  output  N  registered count.
- oRCO  output  1  registered carry/borrow/clamp event flag.
- oZERO  output  1  registered flag, high when oQ == 0.

## Operation
- Reset: oQ = 0, oRCO = 0 and oZERO = 1, immediately on RESET rising. They hold while RESET = 1, regardless of CLK.
- iENB = 0 at an edge:
  - oQ holds its value.
  - oRCO is 0 after the edge.
  - oZERO keeps tracking oQ.
- iENB = 1, iMODO = 00: next = oQ + 1.
  - Overflow condition: oQ == 2^N−1.
  - Wrap mode: next = 0.
  - Saturate mode: next = 2^N−1.
- iENB = 1, iMODO = 01: next = oQ − 1.
  - Underflow condition: oQ == 0.
  - Wrap mode: next = 2^N−1.
  - Saturate mode: next = 0.
- iENB = 1, iMODO = 10: next = oQ − STEP.
  - Underflow condition: oQ < STEP.
  - Wrap mode: next = (oQ − STEP) mod 2^N.
  - Saturate mode: next = 0.
- iENB = 1, iMODO = 11: next = iD. oRCO is always 0 after a load.
- oRCO after an enabled arithmetic edge:
  - 1 exactly when that operation's overflow/underflow condition held.
  - In both wrap and saturate modes.
  - Otherwise 0.
- Saturate mode at a limit: oRCO = 1 on every enabled edge that keeps pushing past the limit; oQ does not change.
- oZERO is registered and updated on the same edge as oQ: oZERO = (next oQ == 0).
- Arithmetic width:
  - Internal add/subtract is N+1 bits.
  - Bit N of the raw result is the carry/borrow.
  - STEP is zero-extended to N+1 bits.
- Mode may change on any cycle with no dead cycle. Each edge uses the iMODO/iD sampled at that edge only.
- iD is ignored in modes 00/01/10. iMODO is ignored when iENB = 0.

## Timing
- Latency from inputs sampled at edge k to oQ, oRCO and oZERO is one clock: valid after edge k.
- The load path has the same one-cycle latency. There is no extra synchroniser stage on the mode/select inputs.
- oRCO is a one-cycle pulse per event. It is not sticky and is cleared by the next edge that does not meet its condition.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.
- RESET asserted mid-operation: outputs go to reset values asynchronously. An edge coinciding with RESET is ignored.
- RESET deasserted: the first state change occurs on the first rising CLK edge with RESET = 0. Inputs must meet setup for that edge.
- All inputs are synchronous to CLK; setup/hold apply at the rising edge.

## Test plan
- Reset mid-count: N=4, counting up at oQ=7, assert RESET between edges -> oQ=0, oRCO=0, oZERO=1 before the next edge; held through 3 edges while RESET=1.
- Up wrap: N=4, SATURATE=0, load 14, then mode 00 for 3 edges -> oQ = 15, 0, 1; oRCO = 0, 1, 0; oZERO = 0, 1, 0.
- Step-down wrap: N=4, STEP=3, load 2, mode 10 for 2 edges -> oQ = 15 (oRCO=1), then 12 (oRCO=0); from oQ=3, mode 10 -> oQ=0, oRCO=0, oZERO=1.
- Load and enable:
  - oQ=5, iMODO=11, iD=9, iENB=1 -> oQ=9, oRCO=0 after one edge.
  - Then iENB=0, iD=2 for 2 edges -> oQ stays 9, oRCO=0.
- Saturate: N=4, SATURATE=1.
  - Load 1, mode 01 for 3 edges -> oQ = 0, 0, 0; oRCO = 0, 1, 1.
  - Load 15, mode 00 -> oQ=15, oRCO=1.
  - Load 2, mode 10 (STEP=3) -> oQ=0, oRCO=1.
- Back-to-back mode changes: N=4, oQ=0; modes 00, 00, 01, 11 (iD=6), 10 on consecutive edges -> oQ = 1, 2, 1, 6, 3; oRCO stays 0 throughout.
